glycemic_scan_scheduler: RTL and testbench

//  Shares one glycemic-index datapath (abs value + bit count of an 8-bit two's-complement blood sample)

---
 rtl/glycemic_pkg.sv | 24 ++
 rtl/glycemic_scan_scheduler_index_unit.sv | 24 ++
 rtl/glycemic_scan_scheduler.sv | 160 ++++++++++++++++
 tb/tb_glycemic_scan_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/glycemic_pkg.sv
// Shared types and constants for the glycemic scan scheduler.
// Holds the sample/index widths, the FSM state encoding and the bit-count helper.
package glycemic_pkg;

  localparam int SENSOR_W = 8;
  localparam int INDEX_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPUTE = 2'd2,
    REPORT  = 2'd3
  } scanState_e;

  function automatic logic [INDEX_W-1:0] popCount8(input logic [SENSOR_W-1:0] value);
    logic [INDEX_W-1:0] count;
    count = '0;
    for (int i = 0; i < SENSOR_W; i++) begin
      count = count + INDEX_W'(value[i]);
    end
    return count;
  endfunction

endpackage

// File: rtl/glycemic_scan_scheduler_index_unit.sv
// Combinational glycemic-index datapath: bit count of |sample| for a signed 8-bit reading.
// The magnitude stays 8 bits wide, so the most negative sample maps to 8'h80.
module glycemic_index_unit
  import glycemic_pkg::*;
(
  input  logic [SENSOR_W-1:0] sample,
  output logic [INDEX_W-1:0]  glycemicIndex
);

  logic [SENSOR_W-1:0] absValue_s;

  // Two's-complement magnitude of the sample.
  always_comb begin
    absValue_s = sample;
    if (sample[SENSOR_W-1]) begin
      absValue_s = ~sample + 8'd1;
    end else begin
      absValue_s = sample;
    end
  end

  assign glycemicIndex = popCount8(absValue_s);

endmodule

// File: rtl/glycemic_scan_scheduler.sv
// Round-robin scheduler sharing one glycemic-index unit among NUM_CH sensor channels.
// Define ALARM_LATCH_EN to make alarms sticky until cleared through the alarmClear port.
module glycemic_scan_scheduler
  import glycemic_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int ALARM_THRESH = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            chReq,
  input  logic [NUM_CH*SENSOR_W-1:0]   chData,
  output logic [NUM_CH-1:0]            chAck,
  output logic                         idxValid,
  output logic [$clog2(NUM_CH)-1:0]    idxChannel,
  output logic [INDEX_W-1:0]           glycemicIndex,
  output logic [NUM_CH-1:0]            alarm,
  output logic                         busy
`ifdef ALARM_LATCH_EN
  ,
  input  logic [NUM_CH-1:0]            alarmClear
`endif
);

  localparam int CH_W = $clog2(NUM_CH);

  scanState_e          state_r, stateNext_s;
  logic [CH_W-1:0]     rrPtr_r, grant_r, grantSel_s, candPtr_s;
  logic                grantFound_s;
  logic [SENSOR_W-1:0] sampleReg_r;
  logic [INDEX_W-1:0]  idxReg_r, idxUnit_s;
  logic [NUM_CH-1:0]   chAck_r, alarm_r;
  logic                idxValid_r, busy_r, alarmHit_s;
  logic [CH_W-1:0]     idxChannel_r;

  glycemic_index_unit uIndex (
    .sample        (sampleReg_r),
    .glycemicIndex (idxUnit_s)
  );

  // Round-robin arbiter: first requesting channel at or after rrPtr, wrapping.
  always_comb begin
    grantSel_s   = '0;
    grantFound_s = 1'b0;
    candPtr_s    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      candPtr_s = CH_W'((int'(rrPtr_r) + k) % NUM_CH);
      if (!grantFound_s && chReq[candPtr_s]) begin
        grantSel_s   = candPtr_s;
        grantFound_s = 1'b1;
      end else begin
        grantFound_s = grantFound_s;
      end
    end
  end

  // Next-state logic; only IDLE waits, every other state lasts one cycle.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable && grantFound_s) begin
          stateNext_s = CAPTURE;
        end else begin
          stateNext_s = IDLE;
        end
      end
      CAPTURE: stateNext_s = COMPUTE;
      COMPUTE: stateNext_s = REPORT;
      REPORT:  stateNext_s = IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  assign alarmHit_s = (idxReg_r >= INDEX_W'(ALARM_THRESH));

  // State, grant, datapath registers and the registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      rrPtr_r      <= '0;
      grant_r      <= '0;
      sampleReg_r  <= '0;
      idxReg_r     <= '0;
      idxChannel_r <= '0;
      chAck_r      <= '0;
      idxValid_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r    <= stateNext_s;
      chAck_r    <= '0;
      idxValid_r <= 1'b0;
      busy_r     <= (stateNext_s != IDLE);
      case (state_r)
        IDLE: begin
          if (stateNext_s == CAPTURE) begin
            grant_r <= grantSel_s;
            chAck_r <= NUM_CH'(1'b1) << grantSel_s;
          end
        end
        CAPTURE: sampleReg_r <= chData[SENSOR_W*grant_r +: SENSOR_W];
        COMPUTE: begin
          // Result and its tag appear together with the valid pulse in REPORT.
          idxReg_r     <= idxUnit_s;
          idxChannel_r <= grant_r;
          idxValid_r   <= 1'b1;
        end
        REPORT: begin
          if (grant_r == CH_W'(NUM_CH - 1)) begin
            rrPtr_r <= '0;
          end else begin
            rrPtr_r <= grant_r + CH_W'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef ALARM_LATCH_EN
  logic [NUM_CH-1:0] alarmSet_s;

  // Sticky alarm set request for the channel being reported.
  always_comb begin
    alarmSet_s = '0;
    if ((state_r == REPORT) && alarmHit_s) begin
      alarmSet_s = NUM_CH'(1'b1) << grant_r;
    end else begin
      alarmSet_s = '0;
    end
  end

  // Latched alarm bank; a set on the same edge as a clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_r <= '0;
    end else begin
      alarm_r <= (alarm_r & ~alarmClear) | alarmSet_s;
    end
  end
`else
  // Alarm follows the latest result of each channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_r <= '0;
    end else if (state_r == REPORT) begin
      alarm_r[grant_r] <= alarmHit_s;
    end
  end
`endif

  assign chAck         = chAck_r;
  assign idxValid      = idxValid_r;
  assign idxChannel    = idxChannel_r;
  assign glycemicIndex = idxReg_r;
  assign alarm         = alarm_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_glycemic_scan_scheduler.sv
// Scoreboard bench for glycemic_scan_scheduler: a transaction-level model predicts grants,
// results and alarms; a negedge monitor compares whatever the DUT presents.
module tb_glycemic_scan_scheduler;

  localparam int N  = 4;
  localparam int TH = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic [N-1:0]   chReq = '0;
  logic [N*8-1:0] chData = '0;
  logic [N-1:0]   chAck, alarm;
  logic           idxValid, busy;
  logic [1:0]     idxChannel;
  logic [3:0]     glycemicIndex;
`ifdef ALARM_LATCH_EN
  logic [N-1:0]   alarmClear = '0;
`endif

  glycemic_scan_scheduler #(.NUM_CH(N), .ALARM_THRESH(TH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .chReq(chReq), .chData(chData),
    .chAck(chAck), .idxValid(idxValid), .idxChannel(idxChannel),
    .glycemicIndex(glycemicIndex), .alarm(alarm), .busy(busy)
`ifdef ALARM_LATCH_EN
    , .alarmClear(alarmClear)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int ch; int idx; } exp_t;
  typedef struct { int cyc; logic [N-1:0] setM; logic [N-1:0] clrM; } aev_t;
  exp_t ackQ[$];
  exp_t resQ[$];
  aev_t alarmQ[$];

  int checks = 0, errors = 0;
  logic [N-1:0] expAlarm = '0;
  logic [N-1:0] justAcked = '0;
  int rrPtrM = 0, freeAt = 0, lastGrant = -100;
  bit monOn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int refIndex(input logic [7:0] d);
    int sv, mag;
    logic [7:0] m8;
    sv  = int'($signed(d));
    mag = (sv < 0) ? -sv : sv;
    m8  = mag[7:0];
    return $countones(m8);
  endfunction

  // Monitor: apply due alarm events, then compare every presented output.
  exp_t monE;
  logic [N-1:0] monSet, monClr;
  always @(negedge clk) begin
    if (monOn) begin
      monSet = '0;
      monClr = '0;
      for (int i = alarmQ.size() - 1; i >= 0; i--) begin
        if (alarmQ[i].cyc == cyc) begin
          monSet = monSet | alarmQ[i].setM;
          monClr = monClr | alarmQ[i].clrM;
          alarmQ.delete(i);
        end
      end
      expAlarm = (expAlarm & ~monClr) | monSet;
      check("alarm", 64'(alarm), 64'(expAlarm));
      check("busy", 64'(busy), 64'((cyc > lastGrant) && (cyc <= lastGrant + 3)));
      if (ackQ.size() > 0 && ackQ[0].cyc < cyc) begin
        monE = ackQ.pop_front();
        check("ack_missing", 64'(cyc), 64'(monE.cyc));
      end
      if (chAck != '0) begin
        if (ackQ.size() == 0) check("ack_unexpected", 64'(chAck), 64'd0);
        else begin
          monE = ackQ.pop_front();
          check("ack_onehot", 64'(chAck), 64'(1 << monE.ch));
          check("ack_cycle", 64'(cyc), 64'(monE.cyc));
        end
      end
      if (resQ.size() > 0 && resQ[0].cyc < cyc) begin
        monE = resQ.pop_front();
        check("valid_missing", 64'(cyc), 64'(monE.cyc));
      end
      if (idxValid !== 1'b0) begin
        if (resQ.size() == 0) check("valid_unexpected", 64'(idxValid), 64'd0);
        else begin
          monE = resQ.pop_front();
          check("idx_channel", 64'(idxChannel), 64'(monE.ch));
          check("glycemic_index", 64'(glycemicIndex), 64'(monE.idx));
          check("valid_cycle", 64'(cyc), 64'(monE.cyc));
        end
      end
    end
  end

  // Update the model with the inputs about to be sampled, then advance one cycle.
  task automatic tick();
    int c, g, idx;
    logic [7:0] d;
    c = cyc;
    if (rst) begin
      ackQ.delete();
      resQ.delete();
      alarmQ.delete();
      expAlarm  = '0;
      rrPtrM    = 0;
      freeAt    = c + 1;
      lastGrant = -100;
    end else begin
`ifdef ALARM_LATCH_EN
      if (alarmClear != '0) alarmQ.push_back('{c + 1, '0, alarmClear});
`endif
      if (enable && c >= freeAt && chReq != '0) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          int j = (rrPtrM + k) % N;
          if (g < 0 && chReq[j]) g = j;
        end
        d   = chData[8*g +: 8];
        idx = refIndex(d);
        ackQ.push_back('{c + 1, g, 0});
        resQ.push_back('{c + 3, g, idx});
`ifdef ALARM_LATCH_EN
        alarmQ.push_back('{c + 4, (idx >= TH) ? N'(1 << g) : N'(0), N'(0)});
`else
        alarmQ.push_back('{c + 4, (idx >= TH) ? N'(1 << g) : N'(0),
                           (idx >= TH) ? N'(0) : N'(1 << g)});
`endif
        rrPtrM    = (g + 1) % N;
        freeAt    = c + 4;
        lastGrant = c;
      end
    end
    @(negedge clk);
    #1;
    justAcked = chAck;
    chReq     = chReq & ~chAck;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input int ch, input logic [7:0] d);
    chData[8*ch +: 8] = d;
    chReq[ch] = 1'b1;
  endtask

  logic [7:0] edgeVals [5];

  initial begin
    edgeVals[0] = 8'h80; edgeVals[1] = 8'h7F; edgeVals[2] = 8'h00;
    edgeVals[3] = 8'hFF; edgeVals[4] = 8'h01;

    // Reset held two cycles with all channels requesting.
    rst = 1'b1; enable = 1'b1; chReq = 4'b1111;
    chData = {8'h55, 8'h0F, 8'hC3, 8'h81};
    tick();
    monOn = 1'b1;
    tick();
    rst = 1'b0;

    // Round robin with every request re-raised after its ack.
    for (int i = 0; i < 22; i++) begin
      chReq = chReq | ~justAcked;
      tick();
    end
    chReq = '0;
    ticks(6);

    // Single request on channel 0.
    issue(0, 8'hF0);
    ticks(6);

    // Boundary samples on channel 2.
    issue(2, 8'h80); ticks(6);
    issue(2, 8'h7F); ticks(6);
    issue(2, 8'h01); ticks(6);
`ifdef ALARM_LATCH_EN
    alarmClear = 4'b0100; tick();
    alarmClear = '0; ticks(3);
`endif

    // Reset while the FSM is in COMPUTE.
    issue(1, 8'h7F);
    tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    issue(2, 8'hE0);
    ticks(6);

    // Enable dropped during CAPTURE.
    issue(0, 8'h3C); issue(1, 8'h11); issue(3, 8'hFE);
    tick();
    enable = 1'b0;
    ticks(8);
    enable = 1'b1;
    ticks(14);

    // Randomized traffic.
    for (int t = 0; t < 700; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!chReq[i] && !justAcked[i] && $urandom_range(2) == 0)
          issue(i, ($urandom_range(3) == 0) ? edgeVals[$urandom_range(4)] : 8'($urandom));
      end
      enable = ($urandom_range(7) != 0);
      rst    = ($urandom_range(150) == 0);
`ifdef ALARM_LATCH_EN
      alarmClear = ($urandom_range(7) == 0) ? N'($urandom) : N'(0);
`endif
      tick();
    end
    rst = 1'b0; enable = 1'b1;
`ifdef ALARM_LATCH_EN
    alarmClear = '0;
`endif
    ticks(30);
    chReq = '0;
    ticks(8);
    check("queues_drained", 64'(ackQ.size() + resQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
